// File: rtl/rf_write_sched_pkg.sv
//------------------------------------------------------------------------------
// rf_write_sched_pkg
// Shared sizes and encodings for the register-file write sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package rf_write_sched_pkg;

    // Register-file geometry shared with the layer controller
    localparam int LC_RF_DATA_WIDTH = 24;
    localparam int LC_RF_DEPTH      = 256;
    localparam int LC_RF_ADDR_WIDTH = 8;

    // Write sequence: grant, data setup, strobe, data hold, handshake
    typedef enum logic [2:0] {
        RFWS_IDLE   = 3'd0,
        RFWS_SETUP  = 3'd1,
        RFWS_STROBE = 3'd2,
        RFWS_HOLD   = 3'd3,
        RFWS_ACK    = 3'd4
    } rfws_state_e;

    // Requester identity; also the meaning of the round-robin pointer
    typedef enum logic {
        SIDE_BUS = 1'b0,
        SIDE_LOC = 1'b1
    } rfws_side_e;

endpackage : rf_write_sched_pkg

`default_nettype wire

// File: rtl/rf_write_sched_arb.sv
//------------------------------------------------------------------------------
// rf_rr_arb2
// Two-way round-robin arbiter. Bit 0 = BUS, bit 1 = LOC. On contention the
// side that was not granted last wins; the pointer moves only on a grant.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rf_rr_arb2
    import rf_write_sched_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    rfws_side_e ptr_q;
    rfws_side_e ptr_d;

    // Grant selection and pointer update
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_q == SIDE_LOC) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (advance_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[1] ? SIDE_LOC : SIDE_BUS;
        end
    end

    // Pointer register; reset leaves BUS as "last granted" so LOC wins first tie
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ptr_q <= SIDE_BUS;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rf_rr_arb2

`default_nettype wire

// File: rtl/rf_write_sched.sv
//------------------------------------------------------------------------------
// rf_write_sched
// Sequences register-file writes from two 4-phase requesters (BUS, LOC):
// one cycle of DIN setup, a single registered one-hot LOAD pulse, one cycle
// of DIN hold, then the handshake ACK. Out-of-range addresses run the same
// sequence without a LOAD bit and report ADDR_ERR alongside ACK.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rf_write_sched
    import rf_write_sched_pkg::*;
#(
    parameter int RF_DEPTH   = 128,              // must not exceed LC_RF_DEPTH
    parameter int ADDR_WIDTH = LC_RF_ADDR_WIDTH  // 2**ADDR_WIDTH >= RF_DEPTH
) (
    input  logic                        CLK,
    input  logic                        RESETn,
    input  logic                        BUS_REQ,
    input  logic [ADDR_WIDTH-1:0]       BUS_ADDR,
    input  logic [LC_RF_DATA_WIDTH-1:0] BUS_DATA,
    output logic                        BUS_ACK,
    input  logic                        LOC_REQ,
    input  logic [ADDR_WIDTH-1:0]       LOC_ADDR,
    input  logic [LC_RF_DATA_WIDTH-1:0] LOC_DATA,
    output logic                        LOC_ACK,
    output logic                        ADDR_ERR,
    output logic [LC_RF_DATA_WIDTH-1:0] RF_DIN,
    output logic [RF_DEPTH-1:0]         RF_LOAD
);

    rfws_state_e                 state_q,    state_d;
    rfws_side_e                  side_q,     side_d;
    logic [ADDR_WIDTH-1:0]       addr_q,     addr_d;
    logic [LC_RF_DATA_WIDTH-1:0] data_q,     data_d;
    logic                        err_q,      err_d;
    logic [LC_RF_DATA_WIDTH-1:0] din_q,      din_d;
    logic [RF_DEPTH-1:0]         load_q,     load_d;
    logic                        bus_ack_q,  bus_ack_d;
    logic                        loc_ack_q,  loc_ack_d;
    logic                        addr_err_q, addr_err_d;

    logic [1:0]                  arb_req;
    logic [1:0]                  arb_gnt;
    logic                        arb_adv;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic                        sel_err;
    logic                        gnt_req;
    logic [RF_DEPTH-1:0]         dec;

    // A requester is eligible only while its own previous ACK is low
    assign arb_req = {LOC_REQ & ~loc_ack_q, BUS_REQ & ~bus_ack_q};
    assign arb_adv = (state_q == RFWS_IDLE);

    rf_rr_arb2 u_arb (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .req_i     (arb_req),
        .advance_i (arb_adv),
        .gnt_o     (arb_gnt)
    );

    // Address of the winning requester and its range check (extra bit keeps
    // the compare exact when RF_DEPTH == 2**ADDR_WIDTH)
    assign sel_addr = arb_gnt[1] ? LOC_ADDR : BUS_ADDR;
    assign sel_err  = ({1'b0, sel_addr} >= (ADDR_WIDTH+1)'(RF_DEPTH));
    assign gnt_req  = (side_q == SIDE_LOC) ? LOC_REQ : BUS_REQ;

    // One-hot decode of the latched address
    for (genvar i = 0; i < RF_DEPTH; i++) begin : g_dec
        assign dec[i] = (addr_q == ADDR_WIDTH'(i));
    end

    // Next-state and next-output logic for the write sequence
    always_comb begin
        state_d    = state_q;
        side_d     = side_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        din_d      = din_q;
        load_d     = '0;
        bus_ack_d  = bus_ack_q;
        loc_ack_d  = loc_ack_q;
        addr_err_d = addr_err_q;
        case (state_q)
            RFWS_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    side_d  = arb_gnt[1] ? SIDE_LOC : SIDE_BUS;
                    addr_d  = sel_addr;
                    data_d  = arb_gnt[1] ? LOC_DATA : BUS_DATA;
                    err_d   = sel_err;
                    state_d = RFWS_SETUP;
                end
            end
            RFWS_SETUP: begin
                din_d   = data_q;
                state_d = RFWS_STROBE;
            end
            RFWS_STROBE: begin
                load_d  = err_q ? '0 : dec;
                state_d = RFWS_HOLD;
            end
            RFWS_HOLD: begin
                state_d = RFWS_ACK;
            end
            RFWS_ACK: begin
                if (!(bus_ack_q || loc_ack_q)) begin
                    bus_ack_d  = (side_q == SIDE_BUS);
                    loc_ack_d  = (side_q == SIDE_LOC);
                    addr_err_d = err_q;
                end else if (!gnt_req) begin
                    bus_ack_d  = 1'b0;
                    loc_ack_d  = 1'b0;
                    addr_err_d = 1'b0;
                    state_d    = RFWS_IDLE;
                end
            end
            default: begin
                state_d = RFWS_IDLE;
            end
        endcase
    end

    // State, latches and output flops; every output comes straight from a flop
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= RFWS_IDLE;
            side_q     <= SIDE_BUS;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            din_q      <= '0;
            load_q     <= '0;
            bus_ack_q  <= 1'b0;
            loc_ack_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            side_q     <= side_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            din_q      <= din_d;
            load_q     <= load_d;
            bus_ack_q  <= bus_ack_d;
            loc_ack_q  <= loc_ack_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign BUS_ACK  = bus_ack_q;
    assign LOC_ACK  = loc_ack_q;
    assign ADDR_ERR = addr_err_q;
    assign RF_DIN   = din_q;
    assign RF_LOAD  = load_q;

endmodule : rf_write_sched

`default_nettype wire

// File: tb/tb_rf_write_sched.sv
//------------------------------------------------------------------------------
// tb_rf_write_sched
// Directed bench for rf_write_sched with a behavioural register-file model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rf_write_sched;

    localparam int DEPTH = 128;
    localparam int AW    = 8;
    localparam int DW    = 24;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          BUS_REQ;
    logic [AW-1:0] BUS_ADDR;
    logic [DW-1:0] BUS_DATA;
    logic          BUS_ACK;
    logic          LOC_REQ;
    logic [AW-1:0] LOC_ADDR;
    logic [DW-1:0] LOC_DATA;
    logic          LOC_ACK;
    logic          ADDR_ERR;
    logic [DW-1:0] RF_DIN;
    logic [DEPTH-1:0] RF_LOAD;

    int n_vec = 0;
    int n_err = 0;

    // Storage model: each register captures RF_DIN on the rising edge of its LOAD
    logic [DW-1:0]    regs [DEPTH];
    int               load_cnt [DEPTH];
    int               load_total = 0;
    logic [DEPTH-1:0] prev_load = '0;

    rf_write_sched #(.RF_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .BUS_REQ  (BUS_REQ),
        .BUS_ADDR (BUS_ADDR),
        .BUS_DATA (BUS_DATA),
        .BUS_ACK  (BUS_ACK),
        .LOC_REQ  (LOC_REQ),
        .LOC_ADDR (LOC_ADDR),
        .LOC_DATA (LOC_DATA),
        .LOC_ACK  (LOC_ACK),
        .ADDR_ERR (ADDR_ERR),
        .RF_DIN   (RF_DIN),
        .RF_LOAD  (RF_LOAD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle storage capture and one-hot check of the strobes
    always @(negedge CLK) begin
        n_vec++;
        assert ($countones(RF_LOAD) <= 1) else begin
            n_err++;
            $error("FAIL onehot: observed %0h expected at most one bit", RF_LOAD);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (RF_LOAD[i] === 1'b1 && prev_load[i] !== 1'b1) begin
                regs[i] = RF_DIN;
                load_cnt[i]++;
                load_total++;
            end
        end
        prev_load = RF_LOAD;
    end

    // Bounded wait for the selected ACK to reach a level; timeout is a miscompare
    task automatic wait_ack(input logic loc, input logic lvl, input string tag);
        int k = 0;
        while (((loc ? LOC_ACK : BUS_ACK) !== lvl) && k < 30) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, loc ? LOC_ACK : BUS_ACK, lvl);
    endtask

    // Complete 4-phase write from one requester
    task automatic do_write(input logic loc, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge CLK); #1;
        if (loc) begin LOC_ADDR = a; LOC_DATA = d; LOC_REQ = 1'b1; end
        else     begin BUS_ADDR = a; BUS_DATA = d; BUS_REQ = 1'b1; end
        wait_ack(loc, 1'b1, "wr_ack_hi");
        @(posedge CLK); #1;
        if (loc) LOC_REQ = 1'b0; else BUS_REQ = 1'b0;
        wait_ack(loc, 1'b0, "wr_ack_lo");
    endtask

    initial begin
        int snap;
        int held;
        logic [DEPTH-1:0] exp_load;
        for (int i = 0; i < DEPTH; i++) begin regs[i] = '0; load_cnt[i] = 0; end
        RESETn = 1'b0;
        BUS_REQ = 1'b0; BUS_ADDR = '0; BUS_DATA = '0;
        LOC_REQ = 1'b0; LOC_ADDR = '0; LOC_DATA = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_load", RF_LOAD, '0);
        chk("rst_din", RF_DIN, '0);
        chk("rst_acks", {BUS_ACK, LOC_ACK, ADDR_ERR}, 3'b000);
        @(posedge CLK); #1 RESETn = 1'b1;

        // Single BUS write, cycle-exact timing (edge N samples REQ)
        @(posedge CLK); #1;
        BUS_ADDR = 8'd5; BUS_DATA = 24'h0000A5; BUS_REQ = 1'b1;
        repeat (2) @(negedge CLK);                  // after N
        chk("t1_din_n0", RF_DIN, 24'h0);
        @(negedge CLK);                             // after N+1
        chk("t1_din_n1", RF_DIN, 24'h0000A5);
        chk("t1_load_n1", RF_LOAD, '0);
        @(negedge CLK);                             // after N+2
        exp_load = '0; exp_load[5] = 1'b1;
        chk("t1_load_n2", RF_LOAD, exp_load);
        @(negedge CLK);                             // after N+3
        chk("t1_load_n3", RF_LOAD, '0);
        chk("t1_ack_n3", BUS_ACK, 1'b0);
        @(negedge CLK);                             // after N+4
        chk("t1_ack_n4", {BUS_ACK, LOC_ACK, ADDR_ERR}, 3'b100);
        @(posedge CLK); #1 BUS_REQ = 1'b0;
        @(negedge CLK);
        chk("t1_ack_wait", BUS_ACK, 1'b1);
        @(negedge CLK);
        chk("t1_ack_drop", BUS_ACK, 1'b0);
        chk("t1_reg5", regs[5], 24'h0000A5);
        chk("t1_cnt5", load_cnt[5], 1);

        // Simultaneous requests: LOC wins the first tie, BUS follows
        @(posedge CLK); #1;
        BUS_ADDR = 8'd3; BUS_DATA = 24'h000011; BUS_REQ = 1'b1;
        LOC_ADDR = 8'd4; LOC_DATA = 24'h000022; LOC_REQ = 1'b1;
        repeat (4) @(negedge CLK);                  // after N+2
        exp_load = '0; exp_load[4] = 1'b1;
        chk("t2_load_loc", RF_LOAD, exp_load);
        repeat (2) @(negedge CLK);                  // after N+4
        chk("t2_acks", {BUS_ACK, LOC_ACK}, 2'b01);
        @(posedge CLK); #1 LOC_REQ = 1'b0;
        wait_ack(1'b1, 1'b0, "t2_loc_lo");
        wait_ack(1'b0, 1'b1, "t2_bus_hi");
        @(posedge CLK); #1 BUS_REQ = 1'b0;
        wait_ack(1'b0, 1'b0, "t2_bus_lo");
        chk("t2_reg3", regs[3], 24'h000011);
        chk("t2_reg4", regs[4], 24'h000022);

        // Out-of-range LOC address: full sequence, no strobe, ADDR_ERR with ACK
        snap = load_total;
        @(posedge CLK); #1;
        LOC_ADDR = 8'd200; LOC_DATA = 24'h00BEEF; LOC_REQ = 1'b1;
        repeat (6) @(negedge CLK);                  // after N+4
        chk("t3_ack_err", {LOC_ACK, ADDR_ERR}, 2'b11);
        @(posedge CLK); #1 LOC_REQ = 1'b0;
        wait_ack(1'b1, 1'b0, "t3_ack_lo");
        chk("t3_err_clr", ADDR_ERR, 1'b0);
        chk("t3_no_load", load_total, snap);

        // REQ held 10 cycles after ACK: one pulse, ACK holds
        @(posedge CLK); #1;
        BUS_ADDR = 8'd7; BUS_DATA = 24'h00003C; BUS_REQ = 1'b1;
        wait_ack(1'b0, 1'b1, "t4_ack_hi");
        held = 0;
        repeat (10) begin
            @(negedge CLK);
            if (BUS_ACK === 1'b1) held++;
        end
        chk("t4_ack_held", held, 10);
        chk("t4_one_pulse", load_cnt[7], 1);
        chk("t4_reg7", regs[7], 24'h00003C);
        @(posedge CLK); #1 BUS_REQ = 1'b0;
        wait_ack(1'b0, 1'b0, "t4_ack_lo");

        // Asynchronous reset while the strobe is high
        @(posedge CLK); #1;
        BUS_ADDR = 8'd9; BUS_DATA = 24'h000077; BUS_REQ = 1'b1;
        repeat (4) @(negedge CLK);                  // after N+2
        exp_load = '0; exp_load[9] = 1'b1;
        chk("t5_load_pre", RF_LOAD, exp_load);
        #1 RESETn = 1'b0; BUS_REQ = 1'b0;
        #1;
        chk("t5_load_rst", RF_LOAD, '0);
        chk("t5_din_rst", RF_DIN, '0);
        chk("t5_acks_rst", {BUS_ACK, LOC_ACK, ADDR_ERR}, 3'b000);
        @(posedge CLK); #1 RESETn = 1'b1;
        do_write(1'b1, 8'd9, 24'h000055);
        chk("t5_reg9", regs[9], 24'h000055);

        // Sweep every register, alternating requesters
        for (int a = 0; a < DEPTH; a++) begin
            do_write(a[0], 8'(a), {16'h0, 8'(a) ^ 8'h5A});
        end
        for (int a = 0; a < DEPTH; a++) begin
            chk($sformatf("sweep_reg%0d", a), regs[a], {16'h0, 8'(a) ^ 8'h5A});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rf_write_sched

`default_nettype wire
